// File: rtl/bct_pkg.sv
// Shared types and defaults for the 68000 bus cycle terminator.
// Region order below is also the select priority order (lowest index wins).
package bct_pkg;

   localparam int NUM_SEL          = 8;
   localparam int DEF_ROM_WAIT     = 1;
   localparam int DEF_RAM_WAIT     = 1;
   localparam int DEF_IO_WAIT      = 4;
   localparam int DEF_CAN_WAIT     = 8;
   localparam int DEF_CW           = 8;
   localparam int DEF_TIMEOUT      = 255;

   typedef enum logic [3:0] {
      REG_ROM,
      REG_RAM,
      REG_IO,
      REG_CAN,
      REG_DRAM,
      REG_GRAPHICS,
      REG_DMA,
      REG_OFFBOARD,
      REG_NONE
   } region_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACK,
      ST_BERR
   } state_e;

   function automatic logic is_internal(region_e r);
      return r inside {REG_ROM, REG_RAM, REG_IO, REG_CAN};
   endfunction

   function automatic logic is_external(region_e r);
      return r inside {REG_DRAM, REG_GRAPHICS, REG_DMA, REG_OFFBOARD};
   endfunction

endpackage

// File: rtl/bus_cycle_terminator_if.sv
// CPU strobe, decoder select and controller acknowledge bundle for the terminator.
// The master side is the CPU/decoder world; the slave side is the terminator.
interface bus_cycle_terminator_if;

   logic AS_L;
   logic OnChipRomSelect_H;
   logic OnChipRamSelect_H;
   logic IOSelect_H;
   logic CanBusSelect_H;
   logic DramSelect_H;
   logic GraphicsCS_L;
   logic DMASelect_L;
   logic OffBoardMemory_H;
   logic DramDtack_L;
   logic GraphicsDtack_L;
   logic DmaDtack_L;
   logic OffBoardDtack_L;
   logic DTACK_L;
   logic BERR_L;
   logic DecodeConflict_H;
   logic CycleActive_H;

   modport master (
      output AS_L, OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H, CanBusSelect_H,
             DramSelect_H, GraphicsCS_L, DMASelect_L, OffBoardMemory_H,
             DramDtack_L, GraphicsDtack_L, DmaDtack_L, OffBoardDtack_L,
      input  DTACK_L, BERR_L, DecodeConflict_H, CycleActive_H
   );

   modport slave (
      input  AS_L, OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H, CanBusSelect_H,
             DramSelect_H, GraphicsCS_L, DMASelect_L, OffBoardMemory_H,
             DramDtack_L, GraphicsDtack_L, DmaDtack_L, OffBoardDtack_L,
      output DTACK_L, BERR_L, DecodeConflict_H, CycleActive_H
   );

endinterface

// File: rtl/bct_region_encoder.sv
// Fixed-priority encoder from active-high selects to a region, plus a
// multiple-select flag. Bit 0 (ROM) has the highest priority.
module bct_region_encoder
   import bct_pkg::*;
(
   input  logic [NUM_SEL-1:0] sel_h,
   output region_e            region,
   output logic               conflict
);

   always_comb begin
      region = REG_NONE;
      for (int i = NUM_SEL - 1; i >= 0; i--) begin
         if (sel_h[i]) region = region_e'(4'(i));
      end
   end

   // clearing the lowest set bit leaves something only if two or more were set
   assign conflict = |(sel_h & (sel_h - NUM_SEL'(1)));

endmodule

// File: rtl/bus_cycle_terminator.sv
// Generates DTACK_L / BERR_L for every 68000 bus cycle from the decoder selects.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no cycle; region latched when AS_L is sampled low
//   WAIT    | counting internal wait states or waiting for external ack
//   ACK     | DTACK_L held low until AS_L is sampled high
//   BERR    | BERR_L held low until AS_L is sampled high
module bus_cycle_terminator
   import bct_pkg::*;
#(
   parameter int ROM_WAIT = DEF_ROM_WAIT,
   parameter int RAM_WAIT = DEF_RAM_WAIT,
   parameter int IO_WAIT  = DEF_IO_WAIT,
   parameter int CAN_WAIT = DEF_CAN_WAIT,
   parameter int CW       = DEF_CW,
   parameter int TIMEOUT  = DEF_TIMEOUT
) (
   input logic                   Clk,
   input logic                   Reset_L,
   bus_cycle_terminator_if.slave bus
);

   // timeout runs as a down-counter: loaded at cycle start, BERR at zero
   localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT - 1);

   state_e          state_q, state_d;
   region_e         region_q, region_d;
   logic [CW-1:0]   waitcnt_q, waitcnt_d;
   logic [CW-1:0]   tocnt_q, tocnt_d;
   logic            dtack_l_q, dtack_l_d;
   logic            berr_l_q, berr_l_d;
   logic            conflict_q, conflict_d;
   logic            active_q, active_d;

   logic [NUM_SEL-1:0] sel_h;
   region_e            enc_region;
   logic               enc_conflict;
   logic               ext_dtack_l;

   assign sel_h = {bus.OffBoardMemory_H, ~bus.DMASelect_L, ~bus.GraphicsCS_L,
                   bus.DramSelect_H, bus.CanBusSelect_H, bus.IOSelect_H,
                   bus.OnChipRamSelect_H, bus.OnChipRomSelect_H};

   bct_region_encoder u_enc (
      .sel_h    (sel_h),
      .region   (enc_region),
      .conflict (enc_conflict)
   );

   function automatic logic [CW-1:0] wait_for(region_e r);
      case (r)
         REG_ROM: return CW'(ROM_WAIT);
         REG_RAM: return CW'(RAM_WAIT);
         REG_IO:  return CW'(IO_WAIT);
         REG_CAN: return CW'(CAN_WAIT);
         default: return '0;
      endcase
   endfunction

   always_comb begin
      ext_dtack_l = 1'b1;
      case (region_q)
         REG_DRAM:     ext_dtack_l = bus.DramDtack_L;
         REG_GRAPHICS: ext_dtack_l = bus.GraphicsDtack_L;
         REG_DMA:      ext_dtack_l = bus.DmaDtack_L;
         REG_OFFBOARD: ext_dtack_l = bus.OffBoardDtack_L;
         default:      ext_dtack_l = 1'b1;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      region_d   = region_q;
      waitcnt_d  = waitcnt_q;
      tocnt_d    = tocnt_q;
      dtack_l_d  = dtack_l_q;
      berr_l_d   = berr_l_q;
      conflict_d = conflict_q;

      unique case (state_q)
         ST_IDLE: begin
            if (!bus.AS_L) begin
               region_d  = enc_region;
               waitcnt_d = wait_for(enc_region);
               tocnt_d   = TO_LOAD;
               state_d   = ST_WAIT;
               if (enc_conflict) conflict_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (bus.AS_L) begin
               state_d = ST_IDLE;
            end else if (is_internal(region_q)) begin
               if (waitcnt_q == '0) begin
                  state_d   = ST_ACK;
                  dtack_l_d = 1'b0;
               end else begin
                  waitcnt_d = waitcnt_q - CW'(1);
               end
            end else if (is_external(region_q) && !ext_dtack_l) begin
               state_d   = ST_ACK;
               dtack_l_d = 1'b0;
            end else if (tocnt_q == '0) begin
               state_d  = ST_BERR;
               berr_l_d = 1'b0;
            end else begin
               tocnt_d = tocnt_q - CW'(1);
            end
         end
         ST_ACK, ST_BERR: begin
            if (bus.AS_L) begin
               state_d   = ST_IDLE;
               dtack_l_d = 1'b1;
               berr_l_d  = 1'b1;
            end
         end
      endcase

      active_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge Clk) begin
      if (!Reset_L) begin
         state_q    <= ST_IDLE;
         region_q   <= REG_NONE;
         waitcnt_q  <= '0;
         tocnt_q    <= '0;
         dtack_l_q  <= 1'b1;
         berr_l_q   <= 1'b1;
         conflict_q <= 1'b0;
         active_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         region_q   <= region_d;
         waitcnt_q  <= waitcnt_d;
         tocnt_q    <= tocnt_d;
         dtack_l_q  <= dtack_l_d;
         berr_l_q   <= berr_l_d;
         conflict_q <= conflict_d;
         active_q   <= active_d;
      end
   end

   assign bus.DTACK_L          = dtack_l_q;
   assign bus.BERR_L           = berr_l_q;
   assign bus.DecodeConflict_H = conflict_q;
   assign bus.CycleActive_H    = active_q;

endmodule

// File: tb/tb_bus_cycle_terminator.sv
// Bench for bus_cycle_terminator: each bus cycle's termination edge is predicted
// from region, wait table, external ack delay, abort point and timeout.
module tb_bus_cycle_terminator;

   localparam int TIMEOUT = 255;
   localparam int W_ROM   = 1;
   localparam int W_RAM   = 1;
   localparam int W_IO    = 4;
   localparam int W_CAN   = 8;
   localparam int NEVER   = 100000;

   int   wt [4] = '{W_ROM, W_RAM, W_IO, W_CAN};
   int   checks = 0;
   int   errors = 0;
   logic exp_conflict = 1'b0;

   logic Clk = 1'b0;
   logic Reset_L;

   bus_cycle_terminator_if bus ();

   bus_cycle_terminator #(
      .ROM_WAIT (W_ROM),
      .RAM_WAIT (W_RAM),
      .IO_WAIT  (W_IO),
      .CAN_WAIT (W_CAN),
      .CW       (8),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .Clk     (Clk),
      .Reset_L (Reset_L),
      .bus     (bus)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic dt, input logic be, input logic act);
      check({tag, ".DTACK_L"}, bus.DTACK_L, dt);
      check({tag, ".BERR_L"}, bus.BERR_L, be);
      check({tag, ".CycleActive_H"}, bus.CycleActive_H, act);
      check({tag, ".DecodeConflict_H"}, bus.DecodeConflict_H, exp_conflict);
   endtask

   // bit order = priority order: ROM, RAM, IO, CAN, DRAM, Graphics, DMA, OffBoard
   task automatic apply_sel(input logic [7:0] s);
      bus.OnChipRomSelect_H = s[0];
      bus.OnChipRamSelect_H = s[1];
      bus.IOSelect_H        = s[2];
      bus.CanBusSelect_H    = s[3];
      bus.DramSelect_H      = s[4];
      bus.GraphicsCS_L      = ~s[5];
      bus.DMASelect_L       = ~s[6];
      bus.OffBoardMemory_H  = s[7];
   endtask

   task automatic set_dtacks(input logic [3:0] low);
      bus.DramDtack_L     = ~low[0];
      bus.GraphicsDtack_L = ~low[1];
      bus.DmaDtack_L      = ~low[2];
      bus.OffBoardDtack_L = ~low[3];
   endtask

   // r: 0..7 region, 8 = unmapped. extra: lower-priority selects also raised.
   // d: WAIT edge (1-based) at which the region's external ack is first seen low.
   // a: WAIT edge at which AS_L is first seen high (0 = never). h: extra hold edges.
   task automatic run_cycle(input string tag, input int r, input logic [7:0] extra,
                            input int d, input int a, input int h);
      logic [7:0] sel;
      logic [3:0] lo;
      int         k_term;
      logic       term_berr;
      sel = 8'h00;
      if (r < 8) sel = (8'h01 << r) | (extra & (8'hFE << r));
      if ($countones(sel) > 1) exp_conflict = 1'b1;
      if (r < 4) begin
         k_term = 1 + wt[r];
         term_berr = 1'b0;
      end else if (r < 8 && d <= TIMEOUT) begin
         k_term = d;
         term_berr = 1'b0;
      end else begin
         k_term = TIMEOUT;
         term_berr = 1'b1;
      end
      apply_sel(sel);
      set_dtacks(4'h0);
      bus.AS_L = 1'b0;
      tick();
      expect_out({tag, ".start"}, 1'b1, 1'b1, 1'b1);
      for (int k = 1; k <= k_term; k++) begin
         apply_sel(8'($urandom));
         lo = 4'($urandom);
         if (r >= 4 && r < 8) lo[2'(r - 4)] = (k >= d);
         set_dtacks(lo);
         if (a > 0 && k >= a) bus.AS_L = 1'b1;
         tick();
         if (a > 0 && k >= a) begin
            expect_out({tag, ".abort"}, 1'b1, 1'b1, 1'b0);
            return;
         end
         if (k < k_term) begin
            if (k <= 3 || k > k_term - 3) expect_out({tag, ".wait"}, 1'b1, 1'b1, 1'b1);
         end else begin
            expect_out({tag, ".term"}, term_berr, ~term_berr, 1'b1);
         end
      end
      for (int j = 0; j < h; j++) begin
         tick();
         expect_out({tag, ".hold"}, term_berr, ~term_berr, 1'b1);
      end
      bus.AS_L = 1'b1;
      set_dtacks(4'h0);
      tick();
      expect_out({tag, ".release"}, 1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      Reset_L = 1'b0;
      bus.AS_L = 1'b1;
      apply_sel(8'h00);
      set_dtacks(4'h0);
      tick();
      tick();
      expect_out("reset", 1'b1, 1'b1, 1'b0);
      Reset_L = 1'b1;
      tick();
      expect_out("idle", 1'b1, 1'b1, 1'b0);

      run_cycle("io", 2, 8'h00, NEVER, 0, 3);
      run_cycle("dram", 4, 8'h00, 2, 0, 1);
      run_cycle("unmapped", 8, 8'h00, NEVER, 0, 2);
      run_cycle("dram_stuck", 4, 8'h00, NEVER, 0, 0);
      run_cycle("dma_at_timeout", 6, 8'h00, TIMEOUT, 0, 0);
      run_cycle("can_abort", 3, 8'h00, NEVER, 4, 0);
      run_cycle("can_full", 3, 8'h00, NEVER, 0, 0);
      run_cycle("ram", 1, 8'h00, NEVER, 0, 0);
      run_cycle("rom_io", 0, 8'h04, NEVER, 0, 1);
      run_cycle("gfx_after_conflict", 5, 8'h00, 5, 0, 0);

      // reset while an IO cycle is still counting wait states
      apply_sel(8'h04);
      bus.AS_L = 1'b0;
      tick();
      tick();
      tick();
      Reset_L = 1'b0;
      tick();
      exp_conflict = 1'b0;
      expect_out("reset_mid_wait", 1'b1, 1'b1, 1'b0);
      Reset_L = 1'b1;
      bus.AS_L = 1'b1;
      tick();
      expect_out("post_reset_idle", 1'b1, 1'b1, 1'b0);

      for (int n = 0; n < 40; n++) begin
         int r, d, a, h;
         logic [7:0] extra;
         r = $urandom_range(0, 8);
         extra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         d = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(1, 12);
         a = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 10) : 0;
         h = $urandom_range(0, 3);
         run_cycle("rand", r, extra, d, a, h);
         if ($urandom_range(0, 1) == 1) begin
            bus.AS_L = 1'b1;
            tick();
            expect_out("rand.gap", 1'b1, 1'b1, 1'b0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_cycle_terminator.md
Name: bus_cycle_terminator

Overview:
- Sits directly downstream of the system address decoder.
- Consumes the per-region chip selects and the 68000 bus strobes, and generates the cycle-termination handshake back to the CPU: DTACK_L, or BERR_L on timeout.
- On-chip regions get a parameterised fixed wait count. Regions served by their own controllers (DRAM, graphics, DMA, off-board) pass through that controller's acknowledge.
- Unselected addresses are terminated by a bus-error watchdog.

Parameters:
ROM_WAIT, 1, wait cycles for OnChipRom region
RAM_WAIT, 1, wait cycles for OnChipRam region
IO_WAIT, 4, wait cycles for IO region
CAN_WAIT, 8, wait cycles for CanBus region
CW, 8, width of wait and timeout counters
TIMEOUT, 255, WAIT-state cycles before BERR_L (must be < 2^CW)

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset_L  in  1  synchronous active-low reset, sampled on rising edge of Clk
AS_L  in  1  CPU address strobe
OnChipRomSelect_H  in  1  decoder select
OnChipRamSelect_H  in  1  decoder select
IOSelect_H  in  1  decoder select
CanBusSelect_H  in  1  decoder select
DramSelect_H  in  1  decoder select, external-ack region
GraphicsCS_L  in  1  decoder select (active low), external-ack region
DMASelect_L  in  1  decoder select (active low), external-ack region
OffBoardMemory_H  in  1  decoder select, external-ack region
DramDtack_L  in  1  acknowledge from DRAM controller
GraphicsDtack_L  in  1  acknowledge from graphics controller
DmaDtack_L  in  1  acknowledge from DMA controller
OffBoardDtack_L  in  1  acknowledge from off-board bus
DTACK_L  out  1  registered data acknowledge to CPU
BERR_L  out  1  registered bus error to CPU
DecodeConflict_H  out  1  sticky flag: more than one select seen at cycle start
CycleActive_H  out  1  high in any state other than IDLE

Behaviour:
- Reset (Reset_L=0 at an edge):
  - state=IDLE, DTACK_L=1, BERR_L=1, DecodeConflict_H=0, counters=0.
  - Applies mid-cycle too; outputs inactive after that edge.
- States: IDLE, WAIT, ACK, BERR.
- IDLE:
  - At an edge with AS_L=0, latch the region by fixed priority ROM>RAM>IO>CAN>DRAM>Graphics>DMA>OffBoard>NONE.
  - Load waitcnt with the region's wait parameter (0 for external and NONE regions). Clear tocnt. Go to WAIT.
  - If ≥2 selects are active at that edge, set DecodeConflict_H. It clears only on reset.
- WAIT, each edge, first match wins:
  - AS_L=1 (aborted cycle): go to IDLE, no ack.
  - Internal region, waitcnt==0: go to ACK; DTACK_L=0 registered at this edge.
  - Internal region, waitcnt>0: decrement waitcnt.
  - External region whose Dtack input=0 at this edge: go to ACK; DTACK_L=0.
  - tocnt==TIMEOUT-1: go to BERR; BERR_L=0.
  - Otherwise: increment tocnt (saturating, never wraps).
- Precedence inside WAIT: abort > acknowledge > timeout.
  - An acknowledge on the same edge as timeout gives DTACK, not BERR.
  - Timeout applies to every region. A stuck external controller yields BERR.
- Latency: AS_L sampled low at edge N; internal region with wait W asserts DTACK_L low after edge N+1+W.
  - External region: DTACK_L low one edge after the external Dtack is sampled low.
- ACK / BERR:
  - Hold DTACK_L (or BERR_L) low until an edge samples AS_L=1.
  - At that edge release to 1 and return to IDLE.
  - A new cycle cannot start until the next edge, so there is always ≥1 IDLE cycle between cycles.
- Active-low selects are inverted internally before priority encoding.
- Select inputs are evaluated only at the cycle-start edge. Changes during WAIT are ignored.
- The external Dtack input considered is the latched region's only. Other Dtack inputs are ignored.
- DTACK_L and BERR_L are never low simultaneously.

Decomposition:
- Shared package bct_pkg holds:
  - region enum (REG_ROM..REG_OFFBOARD, REG_NONE);
  - state enum;
  - default wait constants.
- One sub-module, bct_region_encoder: combinational priority encoder. Inputs are the selects; outputs are region plus conflict flag.
- Counters and the FSM stay in the top module.

Test Plan:
- IO read: AS_L low at edge 10, IOSelect_H=1 -> DTACK_L low after edge 15. AS_L high at edge 20 -> DTACK_L high after edge 20, IDLE.
- DRAM access: DramSelect_H=1, DramDtack_L low at edge 30 -> DTACK_L low after edge 31. Toggling GraphicsDtack_L during the cycle has no effect.
- Unmapped address (no selects), AS_L held low -> BERR_L low after 256 edges from cycle start, DTACK_L stays 1. Release AS_L -> BERR_L high.
- Abort: CAN access, AS_L raised after 3 WAIT cycles -> no DTACK_L, IDLE next edge. Next cycle still gets full CAN_WAIT.
- Conflict: ROM and IO selects both high at start -> ROM timing (DTACK_L after edge N+2) and DecodeConflict_H=1, sticky across later cycles.
- Reset mid-WAIT: Reset_L=0 during an IO wait -> DTACK_L=1, BERR_L=1, CycleActive_H=0 after that edge. DecodeConflict_H cleared.
